// File: rtl/simd_dot_mac.sv
// simd_dot_mac: packed-SIMD dot-product multiply-accumulate unit.
// Three registered stages (MUL -> REDUCE -> ACC/output) with valid/ready
// backpressure, transaction-ID pass-through and synchronous flush.
// Optional build macro: SIMD_DOT_MAC_SATURATE_EN (clamp result on overflow
// instead of wrapping).
module simd_dot_mac #(
  parameter int XLEN          = 32,
  parameter int LANE_W        = 8,
  parameter int TRANS_ID_BITS = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          a_i,
  input  logic [XLEN-1:0]          b_i,
  input  logic [XLEN-1:0]          c_i,
  input  logic                     a_signed_i,
  input  logic                     b_signed_i,
  input  logic                     accum_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     overflow_o
);

  localparam int NUM_LANES = XLEN / LANE_W;
  localparam int PROD_W    = 2 * LANE_W + 2;
  localparam int SUM_W     = PROD_W + $clog2(NUM_LANES);
  // Final adder is one bit wider than the larger of the reduced sum and XLEN,
  // so neither the dot product nor the accumulator is ever truncated before
  // the overflow decision.
  localparam int ACC_W     = ((SUM_W > XLEN) ? SUM_W : XLEN) + 1;

  // Handshake: a stage moves when the stage after it is empty or moving.
  logic out_adv;
  logic s2_adv;
  logic s1_adv;

  // Stage 1 (MUL) registers
  logic                        s1_valid;
  logic signed [PROD_W-1:0]    s1_prod [NUM_LANES];
  logic [XLEN-1:0]             s1_c;
  logic                        s1_accum;
  logic [TRANS_ID_BITS-1:0]    s1_id;

  // Stage 2 (REDUCE) registers
  logic                        s2_valid;
  logic signed [SUM_W-1:0]     s2_sum;
  logic [XLEN-1:0]             s2_c;
  logic                        s2_accum;
  logic [TRANS_ID_BITS-1:0]    s2_id;

  // Combinational stage results
  logic signed [LANE_W:0]      ext_a [NUM_LANES];
  logic signed [LANE_W:0]      ext_b [NUM_LANES];
  logic signed [PROD_W-1:0]    prod  [NUM_LANES];
  logic signed [SUM_W-1:0]     sum;
  logic signed [ACC_W-1:0]     sum_ext;
  logic signed [ACC_W-1:0]     c_ext;
  logic signed [ACC_W-1:0]     acc_total;
  logic [ACC_W-XLEN:0]         top_bits;
  logic                        ovf;
  logic [XLEN-1:0]             res;

  assign out_adv = ~valid_o | ready_i;
  assign s2_adv  = ~s2_valid | out_adv;
  assign s1_adv  = ~s1_valid | s2_adv;
  assign ready_o = s1_adv;

  // Lane-wise widening (sign or zero bit) and signed multiply.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      ext_a[l] = {a_signed_i & a_i[l*LANE_W + LANE_W - 1], a_i[l*LANE_W +: LANE_W]};
      ext_b[l] = {b_signed_i & b_i[l*LANE_W + LANE_W - 1], b_i[l*LANE_W +: LANE_W]};
      prod[l]  = PROD_W'(ext_a[l]) * PROD_W'(ext_b[l]);
    end
  end

  // Full-width signed reduction of the registered lane products.
  always_comb begin
    sum = {SUM_W{1'b0}};
    for (int l = 0; l < NUM_LANES; l++) begin
      sum = sum + SUM_W'(s1_prod[l]);
    end
  end

  // Accumulate, detect signed overflow and form the final result.
  always_comb begin
    sum_ext = ACC_W'(s2_sum);
    c_ext   = ACC_W'($signed(s2_c));
    if (s2_accum) begin
      acc_total = sum_ext + c_ext;
    end else begin
      acc_total = sum_ext;
    end
    // In range iff every bit from the XLEN sign position upward agrees.
    top_bits = acc_total[ACC_W-1:XLEN-1];
    ovf      = ~((&top_bits) | ~(|top_bits));
`ifdef SIMD_DOT_MAC_SATURATE_EN
    if (ovf) begin
      if (acc_total[ACC_W-1]) begin
        res = {1'b1, {(XLEN-1){1'b0}}};
      end else begin
        res = {1'b0, {(XLEN-1){1'b1}}};
      end
    end else begin
      res = acc_total[XLEN-1:0];
    end
`else
    res = acc_total[XLEN-1:0];
`endif
  end

  // Stage valid bits; flush empties the whole pipe and drops the input op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      valid_o  <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= valid_i;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (out_adv) begin
        valid_o <= s2_valid;
      end
    end
  end

  // Stage 1 data: capture products and side-band when a new op enters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        s1_prod[l] <= {PROD_W{1'b0}};
      end
      s1_c     <= {XLEN{1'b0}};
      s1_accum <= 1'b0;
      s1_id    <= {TRANS_ID_BITS{1'b0}};
    end else if (s1_adv & valid_i & ~flush_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        s1_prod[l] <= prod[l];
      end
      s1_c     <= c_i;
      s1_accum <= accum_i;
      s1_id    <= trans_id_i;
    end
  end

  // Stage 2 data: capture the reduced sum when stage 1 hands over an op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_sum   <= {SUM_W{1'b0}};
      s2_c     <= {XLEN{1'b0}};
      s2_accum <= 1'b0;
      s2_id    <= {TRANS_ID_BITS{1'b0}};
    end else if (s2_adv & s1_valid & ~flush_i) begin
      s2_sum   <= sum;
      s2_c     <= s1_c;
      s2_accum <= s1_accum;
      s2_id    <= s1_id;
    end
  end

  // Output registers: hold while stalled, load when stage 2 hands over.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o   <= {XLEN{1'b0}};
      trans_id_o <= {TRANS_ID_BITS{1'b0}};
      overflow_o <= 1'b0;
    end else if (out_adv & s2_valid & ~flush_i) begin
      result_o   <= res;
      trans_id_o <= s2_id;
      overflow_o <= ovf;
    end
  end

endmodule

// File: tb/tb_simd_dot_mac.sv
// Self-checking bench for simd_dot_mac: an 8-bit-lane instance and a
// 16-bit-lane instance share stimulus; expectations come from an
// integer-arithmetic dot-product model.
module tb_simd_dot_mac;

  logic        clk;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] c_i;
  logic        a_signed_i;
  logic        b_signed_i;
  logic        accum_i;
  logic [1:0]  trans_id_i;

  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [1:0]  trans_id_o;
  logic        overflow_o;

  logic        ready16;
  logic        valid16;
  logic [31:0] result16;
  logic [1:0]  id16;
  logic        ovf16;

  int n_vec = 0;
  int n_err = 0;

  // samples taken at the falling edge before each rising edge
  logic        acc_s, hs_s, vo_s, rdy_s, ovf_s;
  logic [31:0] res_s;
  logic [1:0]  id_s;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  id;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  simd_dot_mac #(.XLEN(32), .LANE_W(8), .TRANS_ID_BITS(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .a_signed_i(a_signed_i), .b_signed_i(b_signed_i), .accum_i(accum_i),
    .trans_id_i(trans_id_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .trans_id_o(trans_id_o), .overflow_o(overflow_o)
  );

  simd_dot_mac #(.XLEN(32), .LANE_W(16), .TRANS_ID_BITS(2)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready16), .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .a_signed_i(a_signed_i), .b_signed_i(b_signed_i), .accum_i(accum_i),
    .trans_id_i(trans_id_i), .valid_o(valid16), .ready_i(ready_i),
    .result_o(result16), .trans_id_o(id16), .overflow_o(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: interpret each lane as an integer, sum the products, add c.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic as,
                                input logic bs, input logic acc, input int lw,
                                output logic [31:0] res, output logic ovf);
    longint sum;
    longint va;
    longint vb;
    longint span;
    sum  = 0;
    span = longint'(1) << lw;
    for (int i = 0; i < 32 / lw; i++) begin
      va = longint'((a >> (i * lw))) & (span - 1);
      vb = longint'((b >> (i * lw))) & (span - 1);
      if (as && va >= span / 2) va = va - span;
      if (bs && vb >= span / 2) vb = vb - span;
      sum = sum + va * vb;
    end
    if (acc) sum = sum + longint'($signed(c));
    ovf = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
`ifdef SIMD_DOT_MAC_SATURATE_EN
    if (ovf) res = (sum < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else     res = sum[31:0];
`else
    res = sum[31:0];
`endif
  endfunction

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic as, input logic bs,
                          input logic acc, input logic [1:0] id);
    valid_i = 1'b1; a_i = a; b_i = b; c_i = c;
    a_signed_i = as; b_signed_i = bs; accum_i = acc; trans_id_i = id;
  endtask

  task automatic tick();
    @(negedge clk);
    acc_s = valid_i & ready_o & ~flush_i;
    hs_s  = valid_o & ready_i;
    vo_s  = valid_o;
    rdy_s = ready_o;
    res_s = result_o;
    id_s  = trans_id_o;
    ovf_s = overflow_o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    a_i = 32'h0; b_i = 32'h0; c_i = 32'h0; a_signed_i = 1'b0;
    b_signed_i = 1'b0; accum_i = 1'b0; trans_id_i = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_vec++; if (result_o !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 00000000", result_o); end
    n_vec++; if (trans_id_o !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d expected 0", trans_id_o); end
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow_o); end
    n_vec++; if (valid16 !== 1'b0) begin n_err++; $display("FAIL reset_valid16: got %b expected 0", valid16); end
    rst_i = 1'b0;
    #1;
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
  endtask

  // Single op through an idle pipe: exact 3-edge latency and result value.
  task automatic test_plan_vector(input string name, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] c,
                                  input logic as, input logic bs, input logic acc,
                                  input logic [1:0] id, input logic [31:0] exp_res,
                                  input logic exp_ovf);
    ready_i = 1'b1;
    drive_op(a, b, c, as, bs, acc, id);
    tick();
    valid_i = 1'b0;
    tick();
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL %s_early: valid_o got %b expected 0", name, valid_o); end
    tick();
    n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL %s_valid: got %b expected 1", name, valid_o); end
    n_vec++; if (result_o !== exp_res) begin n_err++; $display("FAIL %s_result: got %h expected %h", name, result_o, exp_res); end
    n_vec++; if (overflow_o !== exp_ovf) begin n_err++; $display("FAIL %s_ovf: got %b expected %b", name, overflow_o, exp_ovf); end
    n_vec++; if (trans_id_o !== id) begin n_err++; $display("FAIL %s_id: got %0d expected %0d", name, trans_id_o, id); end
    tick();
  endtask

  task automatic test_lane16();
    logic [31:0] a, b, c, er;
    logic as, bs, acc, eo;
    ready_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin
        a = 32'hFFFF_0002; b = 32'h0003_0004; c = 32'h0;
        as = 1'b1; bs = 1'b0; acc = 1'b0; er = 32'h0000_0005; eo = 1'b0;
      end else begin
        a = $urandom; b = $urandom; c = $urandom;
        as = 1'($urandom_range(0, 1)); bs = 1'($urandom_range(0, 1));
        acc = 1'($urandom_range(0, 1));
        model(a, b, c, as, bs, acc, 16, er, eo);
      end
      drive_op(a, b, c, as, bs, acc, 2'(k));
      tick();
      valid_i = 1'b0;
      tick();
      tick();
      n_vec++; if (valid16 !== 1'b1) begin n_err++; $display("FAIL lane16_valid[%0d]: got %b expected 1", k, valid16); end
      n_vec++; if (result16 !== er) begin n_err++; $display("FAIL lane16_result[%0d]: got %h expected %h", k, result16, er); end
      n_vec++; if (ovf16 !== eo) begin n_err++; $display("FAIL lane16_ovf[%0d]: got %b expected %b", k, ovf16, eo); end
      n_vec++; if (id16 !== 2'(k)) begin n_err++; $display("FAIL lane16_id[%0d]: got %0d expected %0d", k, id16, 2'(k)); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa[4], ob[4], oc[4], er[4];
    logic os_a[4], os_b[4], oacc[4], eo[4];
    int nxt;
    for (int i = 0; i < 4; i++) begin
      oa[i] = $urandom; ob[i] = $urandom; oc[i] = $urandom;
      os_a[i] = 1'($urandom_range(0, 1)); os_b[i] = 1'($urandom_range(0, 1));
      oacc[i] = 1'($urandom_range(0, 1));
      model(oa[i], ob[i], oc[i], os_a[i], os_b[i], oacc[i], 8, er[i], eo[i]);
    end
    nxt = 0;
    ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (nxt < 4) drive_op(oa[nxt], ob[nxt], oc[nxt], os_a[nxt], os_b[nxt], oacc[nxt], 2'(nxt));
      else valid_i = 1'b0;
      tick();
      if (acc_s) nxt++;
      n_vec++; if (rdy_s !== (k < 3)) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, rdy_s, (k < 3)); end
      if (k >= 2) begin
        n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_stall_valid[%0d]: got %b expected 1", k, valid_o); end
        n_vec++; if (trans_id_o !== 2'd0) begin n_err++; $display("FAIL b2b_stall_id[%0d]: got %0d expected 0", k, trans_id_o); end
        n_vec++; if (result_o !== er[0]) begin n_err++; $display("FAIL b2b_stall_result[%0d]: got %h expected %h", k, result_o, er[0]); end
      end
    end
    n_vec++; if (nxt !== 3) begin n_err++; $display("FAIL b2b_accepts: got %0d expected 3", nxt); end
    ready_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (nxt < 4) drive_op(oa[nxt], ob[nxt], oc[nxt], os_a[nxt], os_b[nxt], oacc[nxt], 2'(nxt));
      else valid_i = 1'b0;
      tick();
      if (acc_s) nxt++;
      n_vec++; if (hs_s !== 1'b1) begin n_err++; $display("FAIL b2b_drain_hs[%0d]: got %b expected 1", j, hs_s); end
      n_vec++; if (id_s !== 2'(j)) begin n_err++; $display("FAIL b2b_drain_id[%0d]: got %0d expected %0d", j, id_s, j); end
      n_vec++; if (res_s !== er[j]) begin n_err++; $display("FAIL b2b_drain_result[%0d]: got %h expected %h", j, res_s, er[j]); end
      n_vec++; if (ovf_s !== eo[j]) begin n_err++; $display("FAIL b2b_drain_ovf[%0d]: got %b expected %b", j, ovf_s, eo[j]); end
    end
    valid_i = 1'b0;
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b expected 0", valid_o); end
  endtask

  task automatic test_flush();
    logic [31:0] a, b, c, er;
    logic eo;
    ready_i = 1'b1;
    drive_op($urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b1, 2'd0);
    tick();
    drive_op($urandom, $urandom, $urandom, 1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    flush_i = 1'b1;
    drive_op($urandom, $urandom, $urandom, 1'b1, 1'b1, 1'b1, 2'd2);
    tick();
    n_vec++; if (rdy_s !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b expected 1", rdy_s); end
    flush_i = 1'b0;
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid[%0d]: got %b expected 0", k, valid_o); end
      tick();
    end
    a = $urandom; b = $urandom; c = 32'h7FFF_FFF0;
    model(a, b, c, 1'b0, 1'b0, 1'b1, 8, er, eo);
    drive_op(a, b, c, 1'b0, 1'b0, 1'b1, 2'd3);
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL post_flush_valid: got %b expected 1", valid_o); end
    n_vec++; if (result_o !== er) begin n_err++; $display("FAIL post_flush_result: got %h expected %h", result_o, er); end
    n_vec++; if (overflow_o !== eo) begin n_err++; $display("FAIL post_flush_ovf: got %b expected %b", overflow_o, eo); end
    n_vec++; if (trans_id_o !== 2'd3) begin n_err++; $display("FAIL post_flush_id: got %0d expected 3", trans_id_o); end
    tick();
  endtask

  task automatic test_random_stream();
    logic [31:0] er, held_res, cv;
    logic eo, held_ovf, stall_prev;
    logic [1:0] held_id;
    exp_t e;
    stall_prev = 1'b0;
    held_res = 32'h0; held_id = 2'd0; held_ovf = 1'b0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        case ($urandom_range(0, 3))
          0: cv = 32'h7FFF_FFFF;
          1: cv = 32'h8000_0000;
          default: cv = $urandom;
        endcase
        drive_op($urandom, $urandom, cv, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom));
        valid_i = ($urandom_range(0, 9) < 7);
        ready_i = ($urandom_range(0, 9) < 6);
      end else begin
        valid_i = 1'b0;
        ready_i = 1'b1;
      end
      tick();
      if (stall_prev) begin
        n_vec++;
        if ({res_s, id_s, ovf_s} !== {held_res, held_id, held_ovf}) begin
          n_err++;
          $display("FAIL stall_hold[%0d]: got %h/%0d/%b expected %h/%0d/%b", cyc, res_s, id_s, ovf_s, held_res, held_id, held_ovf);
        end
      end
      if (hs_s) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stream_spurious[%0d]: got id %0d expected no output", cyc, id_s);
        end else begin
          e = exp_q.pop_front();
          if ({res_s, id_s, ovf_s} !== {e.res, e.id, e.ovf}) begin
            n_err++;
            $display("FAIL stream_out[%0d]: got %h/%0d/%b expected %h/%0d/%b", cyc, res_s, id_s, ovf_s, e.res, e.id, e.ovf);
          end
        end
      end
      if (acc_s) begin
        model(a_i, b_i, c_i, a_signed_i, b_signed_i, accum_i, 8, er, eo);
        exp_q.push_back('{res: er, id: trans_id_i, ovf: eo});
      end
      stall_prev = vo_s & ~ready_i;
      held_res = res_s; held_id = id_s; held_ovf = ovf_s;
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    ready_i = 1'b0;
    drive_op($urandom, $urandom, $urandom, 1'b1, 1'b1, 1'b0, 2'd1);
    tick();
    drive_op($urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b1, 2'd2);
    tick();
    valid_i = 1'b0;
    tick();
    n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b expected 1", valid_o); end
    #2;
    rst_i = 1'b1;
    #1;
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", valid_o); end
    n_vec++; if (valid16 !== 1'b0) begin n_err++; $display("FAIL midrst_valid16: got %b expected 0", valid16); end
    n_vec++; if (result_o !== 32'h0) begin n_err++; $display("FAIL midrst_result: got %h expected 00000000", result_o); end
    n_vec++; if (trans_id_o !== 2'd0) begin n_err++; $display("FAIL midrst_id: got %0d expected 0", trans_id_o); end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    ready_i = 1'b1;
    tick();
    tick();
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_discard: got %b expected 0", valid_o); end
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", ready_o); end
  endtask

  initial begin
    test_reset();
    test_plan_vector("signed_a", 32'hFFFF_FFFF, 32'h0101_0101, 32'h0, 1'b1, 1'b0, 1'b0, 2'd1, 32'hFFFF_FFFC, 1'b0);
    test_plan_vector("unsigned", 32'hFFFF_FFFF, 32'h0101_0101, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0000_03FC, 1'b0);
    test_plan_vector("min_sq",   32'h8080_8080, 32'h8080_8080, 32'h0, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0001_0000, 1'b0);
`ifdef SIMD_DOT_MAC_SATURATE_EN
    test_plan_vector("pos_ovf", 32'hFFFF_FFFF, 32'h0101_0101, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 2'd0, 32'h7FFF_FFFF, 1'b1);
    test_plan_vector("neg_ovf", 32'h8080_8080, 32'h7F7F_7F7F, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 2'd1, 32'h8000_0000, 1'b1);
`else
    test_plan_vector("pos_ovf", 32'hFFFF_FFFF, 32'h0101_0101, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 2'd0, 32'h8000_03FB, 1'b1);
    test_plan_vector("neg_ovf", 32'h8080_8080, 32'h7F7F_7F7F, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 2'd1, 32'h7FFF_0200, 1'b1);
`endif
    test_plan_vector("acc_neg", 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b0);
    test_lane16();
    test_back_to_back();
    test_flush();
    test_random_stream();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
